vga_frame_renderer: RTL and testbench
=====================================

Name: vga_frame_renderer

Overview:
- Drives the VGA pixel timing that `game_logic` consumes, and turns its per-pixel entity code into colour and sync outputs.
- Generates the horizontal/vertical counters and presents them as `x_out`/`y_out`, which wire to `game_logic`'s `x_in`/`y_in`.
- Samples the returned `entity` code, maps it and the game status flags to 12-bit RGB, and delays `hsync`/`vsync` so all pin outputs stay aligned.
- Sits between `game_logic` and the board VGA pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of `hsync`/`vsync` (0 = active-low)

Ports:
- clk  in  1  pixel clock (25 MHz)
- reset_n  in  1  asynchronous, active-low reset
- entity  in  2  entity code from `game_logic`; valid one clk after the matching `x_out`/`y_out`
- game_over  in  1  game status flag, level
- game_won  in  1  game status flag, level
- x_out  out  10  horizontal counter, 0..H_TOTAL-1
- y_out  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, pipeline-aligned with `rgb`
- vsync  out  1  vertical sync, pipeline-aligned with `rgb`
- rgb  out  12  colour {R[3:0], G[3:0], B[3:0]}
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Derived totals:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800 at defaults).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525 at defaults).
- Reset (`reset_n` low, asynchronous):
  - h and v counters = 0; `x_out` = 0, `y_out` = 0.
  - `hsync` = `vsync` = ~SYNC_ACTIVE.
  - `rgb` = 0; `frame_start` = 0.
  - All pipeline stages cleared to the inactive/blank state.
- Counters:
  - h increments every clk.
  - At h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with h = H_TOTAL-1, both wrap to 0.
  - `x_out`/`y_out` are the counter registers directly (stage 0). They are not clamped during blanking.
- `frame_start`: registered; high for exactly the one clk in which the counters read (0,0). Not asserted during reset, nor on the first (0,0) after reset release.
- Stage 0 decode (combinational from the counters):
  - active = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hs_raw asserted for H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC.
  - vs_raw asserted for V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC.
- Stage 1: register active, hs_raw, vs_raw. In this same cycle `entity` (which `game_logic` registers from stage-0 coordinates) is valid.
- Stage 2 (output registers):
  - `hsync` ← stage-1 hs (mapped to SYNC_ACTIVE polarity); `vsync` likewise.
  - If stage-1 active = 0, `rgb` ← 12'h000.
  - Otherwise `rgb` is selected from `entity` in this priority order:
    - ENT_SNAKE_HEAD → 12'h0F0
    - ENT_SNAKE_TAIL → 12'h0A0
    - ENT_APPLE → 12'hF00
    - ENT_NOTHING → background colour
  - Background colour: `game_won` = 1 → 12'h004; else `game_over` = 1 → 12'h400; else 12'h000.
  - If both flags are high, `game_won` wins.
- Latency: total latency from a counter value to its `rgb`/`hsync`/`vsync` = 2 clk. Sync edges are therefore shifted 2 clk relative to the counters but exact relative to `rgb`.
- `game_over`/`game_won` are sampled at stage 2 with no synchronisation; both are from the same clk domain.
- Unknown/undefined `entity` values cannot occur (2-bit, fully decoded).
- Reset mid-frame:
  - Counters return to (0,0) immediately and the pipeline blanks.
  - After release, the first `rgb` appears 2 clk later for pixel (0,0).
  - No `frame_start` is issued for that restart.

Test Plan:
- Reset, then release; run 800×525 clk → `hsync` low for exactly 96 clk per line, starting 2 clk after h = 656; `vsync` low for exactly 2 lines, starting when v = 490; `frame_start` pulses once per 420000 clk.
- Model `entity` as registered from x/y: HEAD at pixel (320,240), APPLE at (34·16, 9·16) → `rgb` = 12'h0F0 exactly 2 clk after x_out = 320, y_out = 240; 12'hF00 at the apple pixel; 12'h000 elsewhere.
- Force entity = ENT_SNAKE_TAIL constantly → `rgb` = 12'h0A0 only while delayed-active; 12'h000 for 160 clk of every line and for all lines v ≥ 480.
- `game_over` = 1, entity = ENT_NOTHING → visible `rgb` = 12'h400; additionally set `game_won` = 1 → 12'h004; head pixels remain 12'h0F0.
- Assert `reset_n` = 0 at h = 500, v = 100 → counters, `rgb`, `frame_start` = 0 and `hsync`/`vsync` = 1 asynchronously; release → `x_out` counts 0,1,2… from the next clk and `rgb` tracks 2 clk behind.
- Counter boundaries → h = 799 wraps to 0 with v+1; at (799,524) both wrap to (0,0) and `frame_start` = 1 in that cycle only.

Source files
------------

// File: rtl/vga_frame_renderer.sv
// VGA timing generator and colour back end for game_logic: produces the pixel
// counters, maps the returned entity code to 12-bit RGB and aligns the syncs with it.
module vga_frame_renderer #(
   parameter int   H_VISIBLE   = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_VISIBLE   = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  entity,
   input  logic        game_over,
   input  logic        game_won,
   output logic [9:0]  x_out,
   output logic [9:0]  y_out,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef enum logic [1:0] {
      ENT_NOTHING    = 2'd0,
      ENT_SNAKE_HEAD = 2'd1,
      ENT_SNAKE_TAIL = 2'd2,
      ENT_APPLE      = 2'd3
   } entity_e;

   logic        active_s0, hs_s0, vs_s0;
   logic        active_s1, hs_s1, vs_s1;
   logic [11:0] bg_colour;
   logic [11:0] pix_colour;

   // Stage 0: the counters themselves. frame_start is set on the wrapping edge
   // so it is high exactly while the counters read (0,0).
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_out       <= '0;
         y_out       <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (x_out == H_LAST) begin
            x_out <= '0;
            if (y_out == V_LAST) begin
               y_out       <= '0;
               frame_start <= 1'b1;
            end else begin
               y_out <= y_out + 10'd1;
            end
         end else begin
            x_out <= x_out + 10'd1;
         end
      end
   end

   assign active_s0 = (x_out < H_VIS_END) && (y_out < V_VIS_END);
   assign hs_s0     = (x_out >= H_SYNC_BEG) && (x_out < H_SYNC_END);
   assign vs_s0     = (y_out >= V_SYNC_BEG) && (y_out < V_SYNC_END);

   // Stage 1: delay the decode by one clk to line up with game_logic's entity register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_s1 <= 1'b0;
         hs_s1     <= 1'b0;
         vs_s1     <= 1'b0;
      end else begin
         active_s1 <= active_s0;
         hs_s1     <= hs_s0;
         vs_s1     <= vs_s0;
      end
   end

   assign bg_colour = game_won  ? 12'h004 :
                      game_over ? 12'h400 : 12'h000;

   // NOTE: pix_colour gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      pix_colour = bg_colour;
      case (entity_e'(entity))
         ENT_SNAKE_HEAD: pix_colour = 12'h0F0;
         ENT_SNAKE_TAIL: pix_colour = 12'h0A0;
         ENT_APPLE:      pix_colour = 12'hF00;
         default:        pix_colour = bg_colour;
      endcase
   end

   // Stage 2: pin registers; syncs and colour leave on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync <= ~SYNC_ACTIVE;
         vsync <= ~SYNC_ACTIVE;
         rgb   <= 12'h000;
      end else begin
         hsync <= hs_s1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync <= vs_s1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         rgb   <= active_s1 ? pix_colour : 12'h000;
      end
   end

endmodule

// File: tb/tb_vga_frame_renderer.sv
// Directed bench for vga_frame_renderer: full horizontal timing, a shortened frame
// height so whole frames fit in a short run, and a registered entity source.
module tb_vga_frame_renderer;

   localparam int HV = 640, HF = 16, HS = 96, HB = 48;
   localparam int VV = 12,  VF = 2,  VS = 2,  VB = 2;
   localparam int HT = 800, VT = 18, FRAME = HT * VT;   // 14400 clk per frame

   localparam logic [1:0] E_NOTHING = 2'd0, E_HEAD = 2'd1, E_TAIL = 2'd2, E_APPLE = 2'd3;
   localparam int MODE_MAP = 0, MODE_TAIL = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  entity;
   logic        game_over = 1'b0;
   logic        game_won = 1'b0;
   logic [9:0]  x_out, y_out;
   logic        hsync, vsync, frame_start;
   logic [11:0] rgb;

   int mode = MODE_TAIL;
   int checks = 0;
   int errors = 0;

   vga_frame_renderer #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .entity(entity),
      .game_over(game_over), .game_won(game_won),
      .x_out(x_out), .y_out(y_out), .hsync(hsync), .vsync(vsync),
      .rgb(rgb), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] ent_of(input int x, input int y);
      if (x == 320 && y == 6) return E_HEAD;
      if (x == 544 && y == 4) return E_APPLE;
      return E_NOTHING;
   endfunction

   // Stand-in for game_logic: entity registered from the stage-0 coordinates.
   always @(posedge clk)
      entity <= (mode == MODE_TAIL) ? E_TAIL : ent_of(int'(x_out), int'(y_out));

   function automatic logic [11:0] exp_rgb(input int px, input int py, input int m,
                                           input logic go, input logic gw);
      logic [1:0] e;
      if (px >= HV || py >= VV) return 12'h000;
      e = (m == MODE_TAIL) ? E_TAIL : ent_of(px, py);
      case (e)
         E_HEAD:  return 12'h0F0;
         E_TAIL:  return 12'h0A0;
         E_APPLE: return 12'hF00;
         default: return gw ? 12'h004 : (go ? 12'h400 : 12'h000);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_xy(input int x, input int y);
      bit found = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (int'(x_out) == x && int'(y_out) == y) begin
            found = 1;
            break;
         end
      end
      check("wait_xy_reached", 32'(found), 32'd1);
   endtask

   // Called at a negedge with reset_n low and entity forced to TAIL.
   task automatic restart_track();
      reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("restart_x", 32'(x_out), 32'(k));
         check("restart_rgb", 32'(rgb), (k >= 2) ? 32'h0A0 : 32'h000);
      end
      check("restart_y", 32'(y_out), 32'd0);
      check("restart_fs", 32'(frame_start), 32'd0);
   endtask

   // Starts at the negedge where the counters sit at (0,0) just after reset release.
   task automatic scan_frame();
      int rgb_err = 0, cnt_err = 0, hs_err = 0;
      int hs_low = 0, vs_low = 0, fs_cnt = 0;
      int px, py;
      for (int n = 0; n <= FRAME + 1; n++) begin
         if (n > 0) @(negedge clk);
         if (int'(x_out) != n % HT || int'(y_out) != (n / HT) % VT) cnt_err++;
         if (frame_start) fs_cnt++;
         if (n >= 2) begin
            px = (n - 2) % HT;
            py = ((n - 2) / HT) % VT;
            if (rgb !== exp_rgb(px, py, mode, game_over, game_won)) rgb_err++;
            if (hsync !== ((px >= 656 && px < 752) ? 1'b0 : 1'b1)) hs_err++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
         end
         case (n)
            0:         check("fs_first_origin", 32'(frame_start), 32'd0);
            657:       check("hs_before_edge", 32'(hsync), 32'd1);
            658:       check("hs_first_low", 32'(hsync), 32'd0);
            753:       check("hs_last_low", 32'(hsync), 32'd0);
            754:       check("hs_after_edge", 32'(hsync), 32'd1);
            3199:      check("line_end_x", 32'(x_out), 32'd799);
            3200:      check("line_wrap", {x_out, y_out}, {10'd0, 10'd4});
            3746:      check("apple_pixel", 32'(rgb), 32'hF00);
            5122:      check("head_pixel", 32'(rgb), 32'h0F0);
            5123:      check("after_head", 32'(rgb), 32'h000);
            11201:     check("vs_before_edge", 32'(vsync), 32'd1);
            11202:     check("vs_first_low", 32'(vsync), 32'd0);
            12801:     check("vs_last_low", 32'(vsync), 32'd0);
            12802:     check("vs_after_edge", 32'(vsync), 32'd1);
            FRAME - 1: check("frame_last", {x_out, y_out}, {10'd799, 10'd17});
            FRAME:     begin
                          check("frame_wrap", {x_out, y_out}, {10'd0, 10'd0});
                          check("fs_at_wrap", 32'(frame_start), 32'd1);
                       end
            FRAME + 1: check("fs_one_clk", 32'(frame_start), 32'd0);
            default: ;
         endcase
      end
      check("counter_seq_err", 32'(cnt_err), 32'd0);
      check("rgb_map_err", 32'(rgb_err), 32'd0);
      check("hsync_shape_err", 32'(hs_err), 32'd0);
      check("hsync_low_total", 32'(hs_low), 32'd1728);   // 96 clk x 18 lines
      check("vsync_low_total", 32'(vs_low), 32'd1600);   // 2 lines x 800 clk
      check("fs_per_frame", 32'(fs_cnt), 32'd1);
   endtask

   initial begin
      int tail_cnt, other_cnt;

      // Reset state.
      reset_n = 1'b0;
      mode    = MODE_TAIL;
      repeat (3) @(negedge clk);
      check("rst_x", 32'(x_out), 32'd0);
      check("rst_y", 32'(y_out), 32'd0);
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_rgb", 32'(rgb), 32'd0);
      check("rst_fs", 32'(frame_start), 32'd0);
      restart_track();

      // Constant tail: only delayed-active pixels light up, 640 x 12 per frame.
      tail_cnt  = 0;
      other_cnt = 0;
      for (int n = 0; n < FRAME; n++) begin
         @(negedge clk);
         if (rgb == 12'h0A0) tail_cnt++;
         else if (rgb != 12'h000) other_cnt++;
      end
      check("tail_pixels", 32'(tail_cnt), 32'd7680);
      check("tail_other", 32'(other_cnt), 32'd0);

      // Full frame against the entity map.
      @(negedge clk);
      reset_n = 1'b0;
      mode    = MODE_MAP;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      scan_frame();

      // Status-flag background colours.
      game_over = 1'b1;
      game_won  = 1'b1;
      wait_xy(102, 3);
      check("bg_both_flags", 32'(rgb), 32'h004);
      wait_xy(322, 6);
      check("head_over_flags", 32'(rgb), 32'h0F0);
      game_won = 1'b0;
      wait_xy(102, 8);
      check("bg_game_over", 32'(rgb), 32'h400);
      wait_xy(702, 8);
      check("hblank_flags", 32'(rgb), 32'h000);
      game_over = 1'b0;
      game_won  = 1'b1;
      wait_xy(202, 10);
      check("bg_game_won", 32'(rgb), 32'h004);
      wait_xy(102, 14);
      check("vblank_flags", 32'(rgb), 32'h000);

      // Asynchronous reset mid-frame.
      game_won = 1'b0;
      mode     = MODE_TAIL;
      wait_xy(500, 10);
      check("pre_reset_rgb", 32'(rgb), 32'h0A0);
      reset_n = 1'b0;
      #1;
      check("async_x", 32'(x_out), 32'd0);
      check("async_y", 32'(y_out), 32'd0);
      check("async_rgb", 32'(rgb), 32'd0);
      check("async_fs", 32'(frame_start), 32'd0);
      check("async_hsync", 32'(hsync), 32'd1);
      check("async_vsync", 32'(vsync), 32'd1);
      @(negedge clk);
      check("reset_hold_x", 32'(x_out), 32'd0);
      restart_track();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
